// File: rtl/rvv_pkg.sv
// Shared types and helpers for the vector ALU issue sequencer.
// State encoding, vsew codes and element/chunk width math.
package rvv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam int OFF_W = 10;

  localparam logic [2:0] VSEW_8  = 3'd0;
  localparam logic [2:0] VSEW_16 = 3'd1;
  localparam logic [2:0] VSEW_32 = 3'd2;
  localparam logic [2:0] VSEW_64 = 3'd3;

  typedef struct packed {
    logic [10:0] sew;
    logic [10:0] w;
  } sew_w_t;

  function automatic sew_w_t sew_w(
    input logic [2:0] vsew,
    input int         lane_width
  );
    sew_w_t      r;
    logic [10:0] lw;
    r.sew = 11'd8 << vsew;
    lw    = 11'd1 << lane_width;
    r.w   = (r.sew < lw) ? r.sew : lw;
    return r;
  endfunction

endpackage

// File: rtl/rvv_lane_index_gen.sv
// Maps group/chunk counters and vector config to per-lane
// enables, bit offsets and first-chunk flags.
module rvv_lane_index_gen
  import rvv_pkg::*;
#(
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 2,
  parameter int G_W        = 5,
  parameter int C_W        = 7,
  parameter int VL_W       = 5,
  localparam int NL        = 1 << NB_LANES
) (
  input  logic [G_W-1:0]      g_i,
  input  logic [C_W-1:0]      c_i,
  input  logic [2:0]          vsew_i,
  input  logic [VL_W-1:0]     vl_i,
  output logic [NL-1:0]       lane_en_o,
  output logic [NL*OFF_W-1:0] lane_off_o,
  output logic [NL-1:0]       lane_first_o
);

  sew_w_t sw;

  assign sw = sew_w(vsew_i, LANE_WIDTH);

  always_comb begin
    lane_en_o    = '0;
    lane_off_o   = '0;
    lane_first_o = '0;
    for (int i = 0; i < NL; i++) begin
      logic [31:0] e;
      logic [31:0] off;
      logic        en;
      e   = 32'(g_i) * 32'(NL) + 32'(i);
      off = e * 32'(sw.sew) + 32'(c_i) * 32'(sw.w);
      en  = (e < 32'(vl_i));
      lane_en_o[i]    = en;
      lane_first_o[i] = en && (c_i == '0);
      lane_off_o[i*OFF_W +: OFF_W] = en ? off[OFF_W-1:0] : '0;
    end
  end

endmodule

// File: rtl/rvv_alu_sequencer.sv
// Vector ALU issue controller: walks vl elements across the lanes
// chunk by chunk and gathers lane results into the destination.
module rvv_alu_sequencer
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 2,
  localparam int NL        = 1 << NB_LANES,
  localparam int LW        = 1 << LANE_WIDTH,
  localparam int VL_W      = $clog2(VLEN/8) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  input  logic [2:0]          vsew,
  input  logic [VL_W-1:0]     vl,
  input  logic [VLEN-1:0]     vd_init,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [NL-1:0]       lane_en,
  output logic [NL*OFF_W-1:0] lane_off,
  output logic [NL-1:0]       lane_first,
  input  logic [NL*LW-1:0]    lane_res,
  output logic [VLEN-1:0]     vd_out,
  output logic                done,
  output logic                err
);

  localparam int G_W = VL_W;
  localparam int C_W = 7;
  localparam int IW  = $clog2(VLEN);

  state_t            state_q, state_d;
  logic [2:0]        vsew_q, vsew_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [G_W-1:0]    g_q, g_d;
  logic [C_W-1:0]    c_q, c_d;
  logic              err_q, err_d;
  logic [VLEN-1:0]   vd_q, vd_d;

  sew_w_t            sw_in, sw_q;
  logic              cfg_bad;
  logic [31:0]       max_el, vl_clamp;
  logic [31:0]       sew_log, groups;
  logic [3:0]        cpe_log;
  logic              last_c, last_g;
  logic              in_issue;
  logic [31:0]       idx;

  logic [NL-1:0]       gen_en, gen_first;
  logic [NL*OFF_W-1:0] gen_off;

  assign sw_in   = sew_w(vsew, LANE_WIDTH);
  assign sw_q    = sew_w(vsew_q, LANE_WIDTH);
  assign cfg_bad = (vsew > VSEW_64) ||
                   (32'(sw_in.sew) > 32'(VLEN));

  // VLEN/SEW as a shift; only used when the config is legal
  assign max_el   = 32'(VLEN) >> (32'(vsew) + 32'd3);
  assign vl_clamp = (32'(vl) > max_el) ? max_el : 32'(vl);

  assign sew_log = 32'(vsew_q) + 32'd3;
  assign cpe_log = (sew_log > 32'(LANE_WIDTH)) ?
                   4'(sew_log - 32'(LANE_WIDTH)) : 4'd0;
  assign last_c  = (32'(c_q) == ((32'd1 << cpe_log) - 32'd1));
  assign groups  = (32'(vl_q) + 32'(NL - 1)) >> NB_LANES;
  assign last_g  = ((32'(g_q) + 32'd1) == groups);

  rvv_lane_index_gen #(
    .LANE_WIDTH (LANE_WIDTH),
    .NB_LANES   (NB_LANES),
    .G_W        (G_W),
    .C_W        (C_W),
    .VL_W       (VL_W)
  ) u_idx (
    .g_i          (g_q),
    .c_i          (c_q),
    .vsew_i       (vsew_q),
    .vl_i         (vl_q),
    .lane_en_o    (gen_en),
    .lane_off_o   (gen_off),
    .lane_first_o (gen_first)
  );

  assign in_issue    = (state_q == ISSUE);
  assign issue_valid = in_issue;
  assign lane_en     = in_issue ? gen_en : '0;
  assign lane_off    = in_issue ? gen_off : '0;
  assign lane_first  = in_issue ? gen_first : '0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = done && err_q;
  assign vd_out      = vd_q;

  always_comb begin
    state_d = state_q;
    vsew_d  = vsew_q;
    vl_d    = vl_q;
    g_d     = g_q;
    c_d     = c_q;
    err_d   = err_q;
    vd_d    = vd_q;
    idx     = '0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          vsew_d = vsew;
          vl_d   = cfg_bad ? '0 : VL_W'(vl_clamp);
          vd_d   = vd_init;
          err_d  = cfg_bad;
          g_d    = '0;
          c_d    = '0;
          if (cfg_bad || (vl == '0)) state_d = DONE;
          else                       state_d = ISSUE;
        end
      end
      (state_q == ISSUE): begin
        if (issue_ready) begin
          for (int i = 0; i < NL; i++) begin
            if (gen_en[i]) begin
              for (int b = 0; b < LW; b++) begin
                if (b < int'(sw_q.w)) begin
                  idx = 32'(gen_off[i*OFF_W +: OFF_W]) + 32'(b);
                  if (idx < 32'(VLEN))
                    vd_d[idx[IW-1:0]] = lane_res[i*LW + b];
                end
              end
            end
          end
          if (last_c) begin
            c_d = '0;
            if (last_g) begin
              g_d     = '0;
              state_d = DONE;
            end else begin
              g_d = g_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      vsew_q  <= '0;
      vl_q    <= '0;
      g_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      vsew_q  <= vsew_d;
      vl_q    <= vl_d;
      g_q     <= g_d;
      c_q     <= c_d;
      err_q   <= err_d;
      vd_q    <= vd_d;
    end
  end

endmodule

// File: tb/tb_rvv_alu_sequencer.sv
// Directed + random bench for rvv_alu_sequencer against a
// byte-wise vector-add reference model.
module tb_rvv_alu_sequencer;

  localparam int VLEN = 128;
  localparam int NL   = 4;
  localparam int LW   = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [2:0]    vsew = '0;
  logic [4:0]    vl = '0;
  logic [127:0]  vd_init = '0;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [3:0]    lane_en;
  logic [39:0]   lane_off;
  logic [3:0]    lane_first;
  logic [31:0]   lane_res;
  logic [127:0]  vd_out;
  logic          done;
  logic          err;

  logic [127:0]  vs1 = '0;
  logic [127:0]  vs2 = '0;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rvv_alu_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .busy        (busy),
    .vsew        (vsew),
    .vl          (vl),
    .vd_init     (vd_init),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .lane_en     (lane_en),
    .lane_off    (lane_off),
    .lane_first  (lane_first),
    .lane_res    (lane_res),
    .vd_out      (vd_out),
    .done        (done),
    .err         (err)
  );

  // Lane ALU model: 8-bit add of the vs1/vs2 chunk at the lane offset
  always_comb begin
    lane_res = '0;
    for (int i = 0; i < NL; i++) begin
      int o;
      o = int'(lane_off[i*10 +: 10]);
      if (o <= VLEN - 8)
        lane_res[i*8 +: 8] = vs1[o +: 8] + vs2[o +: 8];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int vs, input int vl_in,
                        input int mode, input bit ones);
    int sew, cpe, ve, n, k, cyc, last_hs, g, c, e;
    bit bad, finished;
    logic [127:0] exp_vd;
    logic [3:0]   x_en, x_first;
    logic [39:0]  x_off;
    vs1 = {$urandom, $urandom, $urandom, $urandom};
    vs2 = {$urandom, $urandom, $urandom, $urandom};
    vd_init = ones ? '1 : {$urandom, $urandom, $urandom, $urandom};
    bad = (vs > 3);
    sew = 8 << vs;
    cpe = bad ? 0 : sew / LW;
    ve  = bad ? 0 : ((vl_in > VLEN / sew) ? VLEN / sew : vl_in);
    n   = ((ve + NL - 1) / NL) * cpe;
    exp_vd = vd_init;
    for (int b = 0; b < ve * sew / 8; b++)
      exp_vd[b*8 +: 8] = vs1[b*8 +: 8] + vs2[b*8 +: 8];
    vsew  = 3'(vs);
    vl    = 5'(vl_in);
    start = 1'b1;
    issue_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    last_hs = 0;
    finished = 0;
    for (cyc = 1; cyc <= 200 && !finished; cyc++) begin
      case (mode)
        0:       issue_ready = 1'b1;
        1:       issue_ready = ((cyc % 3) == 1);
        default: issue_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("busy", busy, 1);
      if (done) begin
        chk("done_cycle", cyc, last_hs + 1);
        chk("hs_count", k, n);
        chk("err", err, bad);
        chk("vd_out", vd_out, exp_vd);
        chk("iv_in_done", issue_valid, 0);
        finished = 1;
      end else begin
        chk("issue_valid", issue_valid, k < n);
        if (issue_valid) begin
          g = k / cpe;
          c = k % cpe;
          x_en = '0;
          x_first = '0;
          x_off = '0;
          for (int i = 0; i < NL; i++) begin
            e = g * NL + i;
            if (e < ve) begin
              x_en[i] = 1'b1;
              x_first[i] = (c == 0);
              x_off[i*10 +: 10] = 10'(e * sew + c * LW);
            end
          end
          chk("lane_en", lane_en, x_en);
          chk("lane_off", lane_off, x_off);
          chk("lane_first", lane_first, x_first);
          if (issue_ready) begin
            k++;
            last_hs = cyc;
          end
        end
        @(posedge clk); #1;
      end
    end
    issue_ready = 1'b0;
    if (!finished) begin
      chk("done_timeout", done, 1);
    end else begin
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("vd_hold", vd_out, exp_vd);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs",
        {busy, issue_valid, lane_en, lane_off, lane_first, done, err}, 0);
    chk("rst_vd", vd_out, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16, 0, 0);
    run_op(0, 6, 0, 1);
    run_op(2, 4, 0, 0);
    run_op(3, 2, 0, 0);
    run_op(0, 16, 1, 0);
    run_op(1, 16, 0, 0);

    vs1 = '0;
    vs2 = '0;
    vsew = 3'd0;
    vl = 5'd16;
    vd_init = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_outs",
        {busy, issue_valid, lane_en, lane_off, lane_first, done, err}, 0);
    chk("mid_rst_vd", vd_out, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 0, 0);
    run_op(4, 5, 0, 0);
    run_op(7, 16, 0, 0);

    for (int r = 0; r < 10; r++)
      run_op($urandom_range(0, 3), $urandom_range(0, 16), 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rvv_alu_sequencer.md
Name: rvv_alu_sequencer

Overview:
Issue controller for the vector ALU lanes. On a start handshake it walks the active vector (vl elements of width SEW = 8<<vsew) through 2^NB_LANES lanes of 2^LANE_WIDTH bits. Each cycle it drives per-lane bit offsets, enables and first-chunk flags, then gathers the lane results into a VLEN-bit destination register. It sits between the vector decode/CSR stage and the lane array. It replaces ad-hoc sequencing of regi/res.

Parameters:
VLEN, 128, vector register length in bits (max 1023).
LANE_WIDTH, 3, log2 of lane width in bits (LW = 1<<LANE_WIDTH).
NB_LANES, 2, log2 of lane count (NL = 1<<NB_LANES).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  request pulse; accepted only in IDLE
busy  out  1  high from accept to end of DONE
vsew  in  3  element width code, latched at accept
vl  in  $clog2(VLEN/8)+1  element count, latched at accept
vd_init  in  VLEN  old destination value, latched at accept (tail undisturbed)
issue_valid  out  1  lane signals valid this cycle
issue_ready  in  1  lanes accept this cycle (ALU stall when low)
lane_en  out  NL  per-lane active mask
lane_off  out  NL*10  per-lane bit offset into the vector, 10 bits per lane
lane_first  out  NL  lane holds chunk 0 of its element (ALU clears carry)
lane_res  in  NL*LW  per-lane result, LW bits per lane
vd_out  out  VLEN  assembled destination
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done on illegal config

Behaviour:
- Reset (async, any state) sets state IDLE. All outputs, including vd_out, are 0. Counters are cleared.
- Derived values:
  - SEW = 8<<vsew.
  - W = min(SEW, LW).
  - CPE (chunks per element) = SEW/W.
  - G (groups) = ceil(vl/NL).
  - Issue count = G*CPE.
- Iteration order: chunk counter c is inner (0..CPE-1), group counter g is outer.
  - Element of lane i is e = g*NL+i.
  - lane_off[i] = e*SEW + c*W.
  - lane_en[i] = (e < vl).
  - lane_first[i] = lane_en[i] && c==0.
  - Disabled lanes drive lane_off = 0.
- States:
  - IDLE: start=1 latches vsew, vl, and vd_init into vd_out; busy rises next cycle.
    - If vsew>3 or SEW > VLEN: go to DONE with err=1.
    - Else if vl==0: go to DONE.
    - Else: go to ISSUE.
  - ISSUE: issue_valid=1. On issue_valid&&issue_ready:
    - for each enabled lane, vd_out[lane_off[i] +: W] <= lane_res[i*LW +: W] (low W bits);
    - advance c/g.
    - After the last handshake, go to DONE.
  - DONE: done=1 (err if flagged) for one cycle, then IDLE. vd_out holds until the next accept.
- Stall: while issue_ready=0, lane_en, lane_off, lane_first and counters stay stable.
- start while busy is ignored.
- Latency: accept in cycle 0, first issue in cycle 1. With no stalls, done is in cycle G*CPE+1.
- vl > VLEN/SEW is clamped to VLEN/SEW.
- Bits of vd_out beyond vl*SEW keep their vd_init value.

Decomposition:
- Package rvv_pkg holds:
  - state enum {IDLE, ISSUE, DONE};
  - OFF_W=10;
  - the vsew code constants;
  - a function computing SEW and W from vsew and LANE_WIDTH.
- One sub-module, rvv_lane_index_gen: a combinational map from (g, c, vsew, vl) to lane_en/lane_off/lane_first. The FSM and gather logic stay in the top module.

Test Plan:
All scenarios use defaults: 4 lanes × 8 b, VLEN=128. The bench model computes lane_res = vs1+vs2 chunk at lane_off.
1. vsew=0, vl=16, ready=1 -> 4 issues.
   - Cycle 1: lane_off {0,8,16,24}, lane_en=1111.
   - done in cycle 5.
   - vd_out = 3232eeeed0231467d02314673232eeee for the standard vs1/vs2 pair.
2. vsew=0, vl=6, vd_init all-ones -> 2 issues.
   - Second issue: lane_en=0011, offsets {32,40,0,0}.
   - vd_out[127:48] all ones.
3. vsew=2, vl=4 -> 4 issues.
   - Cycle k offsets {8k, 32+8k, 64+8k, 96+8k}.
   - lane_first=1111 only at k=0.
   - done in cycle 5.
4. vsew=3, vl=2 -> 8 issues.
   - lane_en=0011 throughout.
   - lane0 offset 8c, lane1 offset 64+8c.
5. Case 1 with issue_ready toggling 1,0,0,1,... -> exactly 4 handshakes.
   - Outputs stable during stalls.
   - done one cycle after the 4th handshake.
   - Same vd_out as case 1.
6. Corner configurations:
   - resetn low mid-ISSUE -> all outputs 0 immediately.
   - vl=0 -> done in cycle 1, vd_out=vd_init, no issue_valid.
   - vsew=4 -> done&&err in cycle 1.
